// File: rtl/add_seq.sv
// Nibble-serial adder: accepts two W-bit operands plus a carry-in and ripples
// one 4-bit nibble per cycle, holding the registered sum until it is taken.
module add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   carryin,
    input  logic [4*NIBBLES-1:0]   x,
    input  logic [4*NIBBLES-1:0]   y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   s,
    output logic                   carryout
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    x_reg;
    logic [W-1:0]    y_reg;
    logic            carry_reg;
    logic [CW-1:0]   cnt;
    logic [4:0]      nib_sum;
    logic            last_nib;

    // Operands come from the registered copies so input changes mid-RUN are harmless.
    always_comb begin
        nib_sum  = {1'b0, x_reg[{cnt, 2'b00} +: 4]}
                 + {1'b0, y_reg[{cnt, 2'b00} +: 4]}
                 + {4'b0000, carry_reg};
        last_nib = (cnt == CW'(NIBBLES - 1));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = in_valid ? RUN : IDLE;
            RUN:     state_next = last_nib ? DONE : RUN;
            DONE:    state_next = out_ready ? IDLE : DONE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            x_reg     <= '0;
            y_reg     <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            s         <= '0;
            carryout  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg     <= x;
                        y_reg     <= y;
                        carry_reg <= carryin;
                        s         <= '0;
                        cnt       <= '0;
                    end
                end
                RUN: begin
                    s[{cnt, 2'b00} +: 4] <= nib_sum[3:0];
                    carry_reg            <= nib_sum[4];
                    if (last_nib) begin
                        carryout  <= nib_sum[4];
                        out_valid <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
